// File: rtl/fetch_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer that owns the PC and fetches over a req/ack handshake.
// Optional retired-instruction counter enabled by defining INSTRET_CNT_EN.
module fetch_sequencer #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    output logic                     imem_req,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic                     imem_ack,
    input  logic [DATA_WIDTH-1:0]    imem_rdata,
    output logic [DATA_WIDTH-1:0]    instr,
    output logic                     instr_valid,
    input  logic                     PCsrc,
    input  logic [ADDRESS_WIDTH-1:0] ImmOp,
    input  logic                     RegWrite_in,
    output logic                     RegWrite,
    output logic [ADDRESS_WIDTH-1:0] PC,
    output logic [2:0]               state,
    output logic                     fault,
    output logic [31:0]              instret
);

    // The wait counter only ever needs to reach TIMEOUT_CYCLES-1.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_FAULT     = 3'd5
    } state_t;

    state_t                   state_r;
    state_t                   state_next;
    logic [ADDRESS_WIDTH-1:0] pc_r;
    logic [ADDRESS_WIDTH-1:0] pc_next;
    logic [DATA_WIDTH-1:0]    instr_r;
    logic [CNT_W-1:0]         wait_r;
    logic                     fault_r;
    logic                     fetch_done;
    logic                     fetch_wait;

    assign fetch_done = (state_r == S_FETCH) && imem_ack;
    assign fetch_wait = (state_r == S_FETCH) && !imem_ack;

    // Next-state and next-PC decode.
    always_comb begin
        state_next = state_r;
        pc_next    = pc_r;
        case (state_r)
            S_IDLE: begin
                if (en) begin
                    state_next = S_FETCH;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_FETCH: begin
                if (imem_ack) begin
                    state_next = S_DECODE;
                end else if (wait_r == WAIT_LAST) begin
                    state_next = S_FAULT;
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_DECODE:    state_next = S_EXECUTE;
            S_EXECUTE:   state_next = S_WRITEBACK;
            S_WRITEBACK: begin
                // Modulo-2^ADDRESS_WIDTH add; alignment deliberately left unchecked.
                if (PCsrc) begin
                    pc_next = pc_r + ImmOp;
                end else begin
                    pc_next = pc_r + ADDRESS_WIDTH'(4);
                end
                if (en) begin
                    state_next = S_FETCH;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_FAULT:     state_next = S_FAULT;
            default:     state_next = S_IDLE;
        endcase
    end

    // State, PC, instruction latch, wait counter and sticky fault flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            pc_r    <= RESET_PC;
            instr_r <= '0;
            wait_r  <= '0;
            fault_r <= 1'b0;
        end else begin
            state_r <= state_next;
            pc_r    <= pc_next;
            if (fetch_done) begin
                instr_r <= imem_rdata;
            end else begin
                instr_r <= instr_r;
            end
            if (fetch_wait && (wait_r != WAIT_LAST)) begin
                wait_r <= wait_r + CNT_W'(1);
            end else begin
                wait_r <= '0;
            end
            fault_r <= fault_r | (state_next == S_FAULT);
        end
    end

`ifdef INSTRET_CNT_EN
    logic [31:0] instret_r;

    // Retired-instruction count, one per WRITEBACK exit, wrapping naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            instret_r <= 32'd0;
        end else if (state_r == S_WRITEBACK) begin
            instret_r <= instret_r + 32'd1;
        end else begin
            instret_r <= instret_r;
        end
    end

    assign instret = instret_r;
`else
    assign instret = 32'd0;
`endif

    assign imem_req    = (state_r == S_FETCH);
    assign imem_addr   = pc_r;
    assign instr       = instr_r;
    assign instr_valid = (state_r == S_DECODE);
    assign RegWrite    = (state_r == S_WRITEBACK) && RegWrite_in;
    assign PC          = pc_r;
    assign state       = state_r;
    assign fault       = fault_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: random fetch latencies, branches and write requests against a PC model,
// plus directed timeout and mid-fetch reset scenarios.
module tb_fetch_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0010;

    logic        clk = 1'b0;
    logic        rst, en, imem_req, imem_ack, instr_valid, PCsrc, RegWrite_in, RegWrite, fault;
    logic [31:0] imem_addr, imem_rdata, instr, ImmOp, PC, instret;
    logic [2:0]  state;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] word;
        logic        rw;
    } txn_t;

    txn_t        exp_q[$];
    txn_t        cur;
    logic [31:0] model_pc;
    int          n_txn;

    always #5 clk = ~clk;

    fetch_sequencer #(
        .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(RST_PC), .TIMEOUT_CYCLES(15)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid),
        .PCsrc(PCsrc), .ImmOp(ImmOp), .RegWrite_in(RegWrite_in), .RegWrite(RegWrite),
        .PC(PC), .state(state), .fault(fault), .instret(instret)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the expected instruction on every DECODE pulse, checks the writeback strobe.
    initial begin
        cur = '0;
        forever begin
            @(negedge clk);
            if (instr_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_decode: got instr %h expected no decode", instr);
                end else begin
                    cur = exp_q.pop_front();
                    check("decode_instr", instr, cur.word);
                    check("decode_pc", PC, cur.addr);
                end
            end
            if (state === 3'd4) begin
                check("wb_regwrite", 32'(RegWrite), 32'(cur.rw));
                check("wb_instr_hold", instr, cur.word);
            end else begin
                check("regwrite_gated", 32'(RegWrite), 32'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] word, im;
        logic        ps, rw;
        int          d, cnt;
        rst = 1'b1; en = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0;
        PCsrc = 1'b0; ImmOp = 32'd0; RegWrite_in = 1'b0;
        n_txn = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_pc", PC, RST_PC);
        check("rst_instr", instr, 32'd0);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_instret", instret, 32'd0);
        rst = 1'b0;
        en = 1'b1;
        model_pc = RST_PC;

        for (int t = 0; t < 60; t++) begin
            if (t == 0) begin
                word = 32'h0050_0093; ps = 1'b1; im = 32'hFFFF_FFF8; rw = 1'b1; d = 0;
            end else begin
                word = $urandom;
                ps   = ($urandom_range(0, 2) == 0);
                im   = $urandom;
                rw   = 1'($urandom_range(0, 1));
                d    = ($urandom_range(0, 7) == 0) ? 14 : $urandom_range(0, 4);
            end
            cnt = 0;
            while (imem_req !== 1'b1 && cnt < 50) begin
                @(posedge clk);
                #1;
                cnt++;
            end
            if (imem_req !== 1'b1) begin
                checks++;
                errors++;
                $display("FAIL fetch_start: got imem_req=%b expected 1", imem_req);
                break;
            end
            exp_q.push_back('{addr: model_pc, word: word, rw: rw});
            PCsrc = ps; ImmOp = im; RegWrite_in = rw;
            for (int k = 0; k < d; k++) begin
                check("req_held", 32'(imem_req), 32'd1);
                check("addr_held", imem_addr, model_pc);
                @(posedge clk);
                #1;
            end
            check("addr_at_ack", imem_addr, model_pc);
            check("no_fault", 32'(fault), 32'd0);
            imem_ack = 1'b1; imem_rdata = word;
            @(posedge clk);
            #1;
            imem_ack = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
            model_pc = ps ? model_pc + im : model_pc + 32'd4;
            n_txn++;
            @(posedge clk);
            #1;
            imem_ack = 1'b0;
            en = (t == 59) ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (!en) begin
                repeat (3) @(posedge clk);
                #1;
                check("idle_state", 32'(state), 32'd0);
                check("idle_no_req", 32'(imem_req), 32'd0);
                check("idle_pc", PC, model_pc);
                en = (t != 59);
            end
        end
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("final_pc", PC, model_pc);
`ifdef INSTRET_CNT_EN
        check("instret", instret, 32'(n_txn));
`else
        check("instret_tied", instret, 32'd0);
`endif

        // Fetch timeout: 15 FETCH cycles without ack, then sticky FAULT.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        en = 1'b1;
        @(posedge clk);
        #1;
        cnt = 0;
        while (state === 3'd1 && cnt < 100) begin
            cnt++;
            @(posedge clk);
            #1;
        end
        check("timeout_cycles", 32'(cnt), 32'd15);
        check("fault_state", 32'(state), 32'd5);
        check("fault_flag", 32'(fault), 32'd1);
        check("fault_req", 32'(imem_req), 32'd0);
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #1;
        imem_ack = 1'b0;
        check("fault_ack_ignored", 32'(state), 32'd5);
        check("fault_pc_frozen", PC, RST_PC);
        check("fault_instr", instr, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("fault_rst_state", 32'(state), 32'd0);
        check("fault_rst_flag", 32'(fault), 32'd0);
        rst = 1'b0;

        // Reset landing in the second FETCH wait cycle.
        @(posedge clk);
        #1;
        check("pre_rst_fetch", 32'(state), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_req", 32'(imem_req), 32'd1);
        rst = 1'b1;
        en = 1'b0;
        @(posedge clk);
        #1;
        check("midfetch_rst_state", 32'(state), 32'd0);
        check("midfetch_rst_pc", PC, RST_PC);
        check("midfetch_rst_req", 32'(imem_req), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Multi-cycle sequencer for the reduced RISC-V core.
- Owns the PC and steps each instruction through FETCH, DECODE, EXECUTE and WRITEBACK.
- Fetches from instruction memory over a req/ack handshake.
- Presents the fetched instruction to control and sign-extend.
- Gates the register-file write strobe and selects PC+4 or the branch target from PCsrc/ImmOp.

Parameters:
ADDRESS_WIDTH, 32, width of PC and instruction address
DATA_WIDTH, 32, instruction word width
RESET_PC, 0, PC value loaded on reset
TIMEOUT_CYCLES, 15, FETCH cycles without ack before entering FAULT (minimum 1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
en  input  1  run enable; sampled in IDLE and at the end of WRITEBACK
imem_req  output  1  instruction fetch request
imem_addr  output  ADDRESS_WIDTH  fetch address, equal to PC
imem_ack  input  1  fetch complete; imem_rdata valid this cycle
imem_rdata  input  DATA_WIDTH  fetched instruction word
instr  output  DATA_WIDTH  registered current instruction, feeds control/extend
instr_valid  output  1  one-cycle pulse in DECODE
PCsrc  input  1  branch taken, from control
ImmOp  input  ADDRESS_WIDTH  sign-extended immediate, from extend
RegWrite_in  input  1  raw register write request, from control
RegWrite  output  1  gated write enable to the register file
PC  output  ADDRESS_WIDTH  current program counter
state  output  3  encoded FSM state, for debug
fault  output  1  sticky fetch-timeout flag
instret  output  32  retired-instruction count (see Optional Feature)

Behaviour:
- Reset values: state=IDLE, PC=RESET_PC, instr=0, imem_req=0, instr_valid=0, RegWrite=0, fault=0, wait counter=0, instret=0.
- Reset is synchronous; rst in any state, including mid-FETCH or WRITEBACK, returns to IDLE at the next edge with no PC update. rst has priority over every other event.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4, FAULT=5. Unused codes go to IDLE.
- IDLE: outputs inactive. en=1 -> FETCH.
- FETCH:
  - imem_req=1; imem_addr=PC, held stable until ack.
  - On imem_ack: instr<=imem_rdata, wait counter cleared, -> DECODE.
  - No ack: wait counter increments. When the counter reaches TIMEOUT_CYCLES-1 with no ack, -> FAULT.
  - Ack in the timeout cycle: ack wins.
- DECODE: instr_valid=1 for exactly one cycle -> EXECUTE.
- EXECUTE: single settle cycle -> WRITEBACK.
- WRITEBACK:
  - RegWrite = RegWrite_in, this cycle only; RegWrite is 0 in every other state.
  - PC <= PCsrc ? PC+ImmOp : PC+4. Addition is modulo 2^ADDRESS_WIDTH (wraps, no overflow flag).
  - PC alignment is not checked or forced.
  - Then en=1 -> FETCH, en=0 -> IDLE.
- en deasserted mid-instruction: the instruction completes through WRITEBACK, then the FSM enters IDLE.
- FAULT: imem_req=0, fault=1, PC frozen. Only rst exits.
- imem_ack outside FETCH is ignored. imem_rdata is sampled only on ack in FETCH.
- instr holds the last fetched word until the next accepted ack.
- Latency: with ack in the first FETCH cycle, one instruction takes 4 cycles. Each wait cycle adds 1.
- PCsrc, ImmOp and RegWrite_in are sampled only in WRITEBACK.

Optional Feature:
INSTRET_CNT_EN
- Defined: 32-bit counter increments on every WRITEBACK→next-state transition; wraps 0xFFFFFFFF->0; cleared by rst; drives instret.
- Undefined: no counter register; instret tied to 0.

Test Plan:
1. Reset, then en=1; ack in the req cycle with imem_rdata=0x00500093, PCsrc=0, RegWrite_in=1 -> instr=0x00500093; instr_valid pulses in cycle 2; RegWrite pulses in cycle 4; PC 0x0->0x4; state returns to FETCH.
2. PC=0x10 (RESET_PC=0x10), PCsrc=1, ImmOp=0xFFFFFFF8 -> after WRITEBACK PC=0x08; with INSTRET_CNT_EN, instret=1.
3. Ack delayed 3 cycles -> imem_req and imem_addr stay stable for 4 FETCH cycles; instr captured on the ack cycle; no fault.
4. TIMEOUT_CYCLES=15, no ack -> fault=1 and state=5 after 15 FETCH cycles; imem_req=0; later acks ignored; rst clears to IDLE.
5. en dropped during EXECUTE -> WRITEBACK still completes (RegWrite pulse, PC+4), then IDLE; no new imem_req.
6. rst asserted in the 2nd FETCH wait cycle -> next cycle state=IDLE, PC=RESET_PC, imem_req=0, RegWrite never asserted.
